// File: rtl/ioctl_download_tx.sv
// ROM download source: paces FIFO-buffered upstream bytes onto the ioctl bus, one write per ioctl_ack.
// Optional running byte checksum is built only when IOCTL_TX_CHECKSUM_EN is defined; otherwise checksum is 0.
module ioctl_download_tx #(
  parameter int FIFO_AW      = 2,
  parameter int ADDR_W       = 25,
  parameter int SETUP_CYCLES = 4,
  parameter int TIMEOUT      = 65535
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_start,
  input  logic [ADDR_W-1:0] dl_base,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ioctl_downl,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  input  logic              ioctl_ack,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] byte_count,
  output logic [15:0]       checksum
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int SW    = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_WRITE, S_GAP, S_FINISH
  } state_t;

  state_t r_state, w_next;

  logic [8:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_cnt;

  logic [ADDR_W-1:0]  r_addr, r_byte_count;
  logic [7:0]         r_dout;
  logic               r_cur_last, r_last_seen, r_timeout_err;
  logic [SW-1:0]      r_setup_cnt;
  logic [TW-1:0]      r_wait_cnt;

  logic w_empty, w_full, w_push, w_pop, w_start, w_flush, w_ack_ok, w_timeout;
  logic [8:0] w_rd;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == (FIFO_AW+1)'(DEPTH));
  assign w_push   = s_valid & s_ready;
  assign w_pop    = (r_state == S_FETCH) & ~w_empty;
  assign w_start  = (r_state == S_IDLE) & dl_start;
  assign w_rd     = r_mem[r_rptr];
  // The first WRITE cycle has r_wait_cnt == 0, so an ack there is ignored.
  assign w_ack_ok  = (r_state == S_WRITE) & ioctl_ack & (r_wait_cnt != '0);
  assign w_timeout = (r_state == S_WRITE) & ~w_ack_ok & (r_wait_cnt == TW'(TIMEOUT - 1));
  assign w_flush   = w_timeout | w_start;

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wptr] <= {s_last, s_data};
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (dl_start) w_next = S_SETUP;
      S_SETUP:  if (r_setup_cnt == SW'(SETUP_CYCLES - 1)) w_next = S_FETCH;
      S_FETCH: begin
        if (!w_empty)                       w_next = S_WRITE;
        else if (r_last_seen && r_cur_last) w_next = S_FINISH;
      end
      S_WRITE: begin
        if (w_ack_ok)       w_next = S_GAP;
        else if (w_timeout) w_next = S_FINISH;
      end
      S_GAP:    w_next = r_cur_last ? S_FINISH : S_FETCH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ioctl_downl = 1'b0;
    ioctl_wr    = 1'b0;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_FINISH) & ~r_timeout_err;
    case (r_state)
      S_SETUP, S_FETCH, S_GAP: ioctl_downl = 1'b1;
      S_WRITE: begin
        ioctl_downl = 1'b1;
        ioctl_wr    = 1'b1;
      end
      default: ioctl_downl = 1'b0;
    endcase
    s_ready = ioctl_downl & ~w_full & ~r_last_seen;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_addr        <= '0;
      r_dout        <= '0;
      r_byte_count  <= '0;
      r_cur_last    <= 1'b0;
      r_last_seen   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_setup_cnt   <= '0;
      r_wait_cnt    <= '0;
    end else begin
      if (w_start) begin
        r_addr        <= dl_base;
        r_byte_count  <= '0;
        r_timeout_err <= 1'b0;
        r_last_seen   <= 1'b0;
        r_cur_last    <= 1'b0;
        r_setup_cnt   <= '0;
      end
      if (r_state == S_SETUP) r_setup_cnt <= r_setup_cnt + 1'b1;
      if (w_push && s_last)   r_last_seen <= 1'b1;
      if (w_pop) begin
        r_dout     <= w_rd[7:0];
        r_cur_last <= w_rd[8];
      end
      r_wait_cnt <= (r_state == S_WRITE) ? r_wait_cnt + 1'b1 : '0;
      if (w_ack_ok) begin
        r_addr       <= r_addr + 1'b1;
        r_byte_count <= r_byte_count + 1'b1;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

`ifdef IOCTL_TX_CHECKSUM_EN
  logic [15:0] r_checksum;
  always_ff @(posedge clk_sys) begin
    if (!reset_n || w_start) r_checksum <= '0;
    else if (w_ack_ok)       r_checksum <= r_checksum + {8'h00, r_dout};
  end
  assign checksum = r_checksum;
`else
  assign checksum = 16'h0000;
`endif

  assign ioctl_addr  = r_addr;
  assign ioctl_dout  = r_dout;
  assign byte_count  = r_byte_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ioctl_download_tx.sv
// Directed bench for ioctl_download_tx: a main instance with a scripted ack responder and a short-TIMEOUT instance.
module tb_ioctl_download_tx;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_start = 1'b0;
  logic [24:0] dl_base = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready, ioctl_downl, ioctl_wr, busy, done, timeout_err;
  logic [24:0] ioctl_addr, byte_count;
  logic [7:0]  ioctl_dout;
  logic        ioctl_ack = 1'b0;
  logic [15:0] checksum;

  logic        t_dl_start = 1'b0;
  logic [24:0] t_dl_base = '0;
  logic        t_s_valid = 1'b0;
  logic [7:0]  t_s_data = '0;
  logic        t_s_last = 1'b0;
  logic        t_ioctl_ack = 1'b0;
  logic        t_s_ready, t_ioctl_downl, t_ioctl_wr, t_busy, t_done, t_timeout_err;
  logic [24:0] t_ioctl_addr, t_byte_count;
  logic [7:0]  t_ioctl_dout;
  logic [15:0] t_checksum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_download_tx u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_start(dl_start), .dl_base(dl_base),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_ack(ioctl_ack), .busy(busy), .done(done),
    .timeout_err(timeout_err), .byte_count(byte_count), .checksum(checksum)
  );

  ioctl_download_tx #(.TIMEOUT(16)) u_dut_to (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_start(t_dl_start), .dl_base(t_dl_base),
    .s_valid(t_s_valid), .s_data(t_s_data), .s_last(t_s_last), .s_ready(t_s_ready),
    .ioctl_downl(t_ioctl_downl), .ioctl_wr(t_ioctl_wr), .ioctl_addr(t_ioctl_addr),
    .ioctl_dout(t_ioctl_dout), .ioctl_ack(t_ioctl_ack), .busy(t_busy), .done(t_done),
    .timeout_err(t_timeout_err), .byte_count(t_byte_count), .checksum(t_checksum)
  );

  // Receiver model and bus monitor, sampled on the falling edge.
  int cyc = 0;
  int ack_d1 = 0, ack_d2 = 0;
  int wcnt = 0, push_cnt = 0, done_cnt = 0;
  int downl_cyc = -1, first_wr_cyc = -1, push_at_ack = -1;
  bit first_ack_seen = 1'b0;
  logic rdy_at_ack = 1'b1;
  logic prev_wr = 1'b0, prev_downl = 1'b0;
  logic [24:0] mon_addr[$];
  logic [7:0]  mon_dout[$];
  int          mon_len[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (ioctl_wr) begin
      if (!prev_wr) begin
        mon_addr.push_back(ioctl_addr);
        mon_dout.push_back(ioctl_dout);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      wcnt = wcnt + 1;
    end else begin
      if (prev_wr) begin
        mon_len.push_back(wcnt);
        if (!first_ack_seen) begin
          first_ack_seen = 1'b1;
          push_at_ack = push_cnt;
          rdy_at_ack = s_ready;
        end
      end
      wcnt = 0;
    end
    ioctl_ack = ioctl_wr && ((wcnt == ack_d1) || (wcnt == ack_d2));
    if (s_valid && s_ready) push_cnt = push_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    if (ioctl_downl && !prev_downl && downl_cyc < 0) downl_cyc = cyc;
    prev_wr = ioctl_wr;
    prev_downl = ioctl_downl;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_mon();
    mon_addr.delete();
    mon_dout.delete();
    mon_len.delete();
    push_cnt = 0;
    done_cnt = 0;
    downl_cyc = -1;
    first_wr_cyc = -1;
    push_at_ack = -1;
    first_ack_seen = 1'b0;
    rdy_at_ack = 1'b1;
  endtask

  task automatic start(input logic [24:0] base, output int sc);
    dl_base = base;
    dl_start = 1'b1;
    sc = cyc;
    tick();
    dl_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    n = 0;
    while (!s_ready && n < 500) begin
      tick();
      n++;
    end
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_vec++; if ({ioctl_downl, ioctl_wr, done, busy, timeout_err, s_ready} !== 6'b0) begin n_err++; $display("FAIL reset_ctl: got %b expected 000000", {ioctl_downl, ioctl_wr, done, busy, timeout_err, s_ready}); end
    n_vec++; if (ioctl_addr !== 25'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", ioctl_addr); end
    n_vec++; if (ioctl_dout !== 8'h0) begin n_err++; $display("FAIL reset_dout: got %h expected 0", ioctl_dout); end
    n_vec++; if (byte_count !== 25'h0) begin n_err++; $display("FAIL reset_count: got %h expected 0", byte_count); end
    n_vec++; if (checksum !== 16'h0) begin n_err++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
    n_vec++; if (t_busy !== 1'b0) begin n_err++; $display("FAIL reset_t_busy: got %b expected 0", t_busy); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int sc;
    bit ok;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    clear_mon();
    ack_d1 = 3; ack_d2 = 0;
    start(25'h10000, sc);
    n_vec++; if (ioctl_downl !== 1'b1) begin n_err++; $display("FAIL basic_downl_early: got %b expected 1", ioctl_downl); end
    for (int i = 0; i < 4; i++) send(exp_d[i], i == 3);
    dl_base = 25'h0;
    dl_start = 1'b1;
    tick();
    dl_start = 1'b0;
    wait_idle(500, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_idle: busy got 1 expected 0"); end
    n_vec++; if (downl_cyc - sc != 1) begin n_err++; $display("FAIL basic_downl_lat: got %0d expected 1", downl_cyc - sc); end
    n_vec++; if (first_wr_cyc - sc != 6) begin n_err++; $display("FAIL basic_wr_lat: got %0d expected 6", first_wr_cyc - sc); end
    n_vec++; if (mon_addr.size() != 4) begin n_err++; $display("FAIL basic_npulses: got %0d expected 4", mon_addr.size()); end
    for (int i = 0; i < mon_addr.size() && i < 4; i++) begin
      n_vec++; if (mon_addr[i] !== 25'h10000 + 25'(i)) begin n_err++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, mon_addr[i], 25'h10000 + 25'(i)); end
      n_vec++; if (mon_dout[i] !== exp_d[i]) begin n_err++; $display("FAIL basic_dout[%0d]: got %h expected %h", i, mon_dout[i], exp_d[i]); end
      n_vec++; if (mon_len[i] != 3) begin n_err++; $display("FAIL basic_wrlen[%0d]: got %0d expected 3", i, mon_len[i]); end
    end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); end
    n_vec++; if (byte_count !== 25'd4) begin n_err++; $display("FAIL basic_count: got %0d expected 4", byte_count); end
`ifdef IOCTL_TX_CHECKSUM_EN
    n_vec++; if (checksum !== 16'h00AA) begin n_err++; $display("FAIL basic_checksum: got %h expected 00aa", checksum); end
`else
    n_vec++; if (checksum !== 16'h0000) begin n_err++; $display("FAIL basic_checksum: got %h expected 0000", checksum); end
`endif
    n_vec++; if ({ioctl_downl, timeout_err} !== 2'b00) begin n_err++; $display("FAIL basic_end: got %b expected 00", {ioctl_downl, timeout_err}); end
  endtask

  task automatic test_backpressure();
    int sc;
    bit ok;
    clear_mon();
    ack_d1 = 50; ack_d2 = 0;
    start(25'h200, sc);
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), i == 7);
    wait_idle(2000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_idle: busy got 1 expected 0"); end
    n_vec++; if (push_at_ack != 5) begin n_err++; $display("FAIL bp_pushes: got %0d expected 5", push_at_ack); end
    n_vec++; if (rdy_at_ack !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b expected 0", rdy_at_ack); end
    n_vec++; if (mon_addr.size() != 8) begin n_err++; $display("FAIL bp_npulses: got %0d expected 8", mon_addr.size()); end
    for (int i = 0; i < mon_addr.size() && i < 8; i++) begin
      n_vec++; if (mon_addr[i] !== 25'h200 + 25'(i)) begin n_err++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, mon_addr[i], 25'h200 + 25'(i)); end
      n_vec++; if (mon_dout[i] !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL bp_dout[%0d]: got %h expected %h", i, mon_dout[i], 8'hA0 + 8'(i)); end
    end
    n_vec++; if (byte_count !== 25'd8) begin n_err++; $display("FAIL bp_count: got %0d expected 8", byte_count); end
`ifdef IOCTL_TX_CHECKSUM_EN
    n_vec++; if (checksum !== 16'h051C) begin n_err++; $display("FAIL bp_checksum: got %h expected 051c", checksum); end
`endif
  endtask

  task automatic test_ack_first_cycle();
    int sc;
    bit ok;
    clear_mon();
    ack_d1 = 1; ack_d2 = 5;
    start(25'h300, sc);
    send(8'h5A, 1'b1);
    wait_idle(500, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ack1_idle: busy got 1 expected 0"); end
    n_vec++; if (mon_len.size() != 1 || mon_len[0] != 5) begin n_err++; $display("FAIL ack1_wrlen: got %0d pulses, first len %0d, expected 1 pulse len 5", mon_len.size(), (mon_len.size() > 0) ? mon_len[0] : -1); end
    n_vec++; if (byte_count !== 25'd1) begin n_err++; $display("FAIL ack1_count: got %0d expected 1", byte_count); end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL ack1_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_write();
    int sc, n;
    clear_mon();
    ack_d1 = 3; ack_d2 = 0;
    start(25'h400, sc);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    n = 0;
    while (byte_count !== 25'd2 && n < 200) begin tick(); n++; end
    n_vec++; if (byte_count !== 25'd2) begin n_err++; $display("FAIL rst_precount: got %0d expected 2", byte_count); end
    ack_d1 = 0;
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    n = 0;
    while (!ioctl_wr && n < 200) begin tick(); n++; end
    n_vec++; if (ioctl_wr !== 1'b1) begin n_err++; $display("FAIL rst_prewr: got %b expected 1", ioctl_wr); end
    reset_n = 1'b0;
    tick();
    n_vec++; if ({ioctl_wr, ioctl_downl, s_ready, busy, done} !== 5'b0) begin n_err++; $display("FAIL rst_ctl: got %b expected 00000", {ioctl_wr, ioctl_downl, s_ready, busy, done}); end
    n_vec++; if (byte_count !== 25'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", byte_count); end
    n_vec++; if ({ioctl_addr, ioctl_dout} !== 33'h0) begin n_err++; $display("FAIL rst_bus: got %h/%h expected 0/0", ioctl_addr, ioctl_dout); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    int sc;
    bit ok;
    clear_mon();
    ack_d1 = 3; ack_d2 = 0;
    start(25'h1FFFFFF, sc);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    wait_idle(500, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_idle: busy got 1 expected 0"); end
    n_vec++; if (mon_addr.size() != 2) begin n_err++; $display("FAIL wrap_npulses: got %0d expected 2", mon_addr.size()); end
    if (mon_addr.size() == 2) begin
      n_vec++; if (mon_addr[0] !== 25'h1FFFFFF) begin n_err++; $display("FAIL wrap_addr0: got %h expected 1ffffff", mon_addr[0]); end
      n_vec++; if (mon_addr[1] !== 25'h0) begin n_err++; $display("FAIL wrap_addr1: got %h expected 0000000", mon_addr[1]); end
      n_vec++; if (mon_dout[0] !== 8'hC1) begin n_err++; $display("FAIL wrap_dout0: got %h expected c1", mon_dout[0]); end
      n_vec++; if (mon_dout[1] !== 8'hC2) begin n_err++; $display("FAIL wrap_dout1: got %h expected c2", mon_dout[1]); end
    end
    n_vec++; if (ioctl_addr !== 25'h1) begin n_err++; $display("FAIL wrap_final_addr: got %h expected 0000001", ioctl_addr); end
  endtask

  task automatic test_timeout();
    int n, k;
    t_dl_base = 25'h500;
    t_dl_start = 1'b1;
    tick();
    t_dl_start = 1'b0;
    t_s_valid = 1'b1; t_s_data = 8'h77; t_s_last = 1'b1;
    tick();
    t_s_valid = 1'b0; t_s_last = 1'b0;
    n = 0;
    while (!t_ioctl_wr && n < 50) begin tick(); n++; end
    n_vec++; if (t_ioctl_wr !== 1'b1) begin n_err++; $display("FAIL to_wr: got %b expected 1", t_ioctl_wr); end
    k = 0;
    while (!t_timeout_err && k < 100) begin tick(); k++; end
    n_vec++; if (k != 16) begin n_err++; $display("FAIL to_cycles: got %0d expected 16", k); end
    n_vec++; if ({t_ioctl_wr, t_ioctl_downl, t_done} !== 3'b000) begin n_err++; $display("FAIL to_outputs: got %b expected 000", {t_ioctl_wr, t_ioctl_downl, t_done}); end
    n_vec++; if (t_byte_count !== 25'd0) begin n_err++; $display("FAIL to_count: got %0d expected 0", t_byte_count); end
    tick();
    n_vec++; if ({t_busy, t_timeout_err, t_done} !== 3'b010) begin n_err++; $display("FAIL to_sticky: got %b expected 010", {t_busy, t_timeout_err, t_done}); end
    t_dl_start = 1'b1;
    tick();
    t_dl_start = 1'b0;
    n_vec++; if ({t_timeout_err, t_ioctl_downl} !== 2'b01) begin n_err++; $display("FAIL to_clear: got %b expected 01", {t_timeout_err, t_ioctl_downl}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ack_first_cycle();
    test_reset_mid_write();
    test_wrap();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
